// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, access sizes
// and transaction owner encoding.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   // func3 bit 2 only selects sign/zero extension, so the size lives in [1:0]
   function automatic logic [1:0] size_of(input logic [1:0] func3_lo);
      return func3_lo;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bus of the unified memory port arbiter.
// The slave modport is the arbiter; master is the pipeline plus memory macro.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 14
);
   logic              if_req;
   logic [63:0]       if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;

   logic              d_req;
   logic              d_we;
   logic [63:0]       d_addr;
   logic [2:0]        d_func3;
   logic [63:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [63:0]       d_rdata;
   logic              d_misalign;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_be;
   logic [63:0]       mem_wdata;
   logic [63:0]       mem_rdata;

   logic              stall_if;
   logic              stall_mem;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_func3, d_wdata,
      output d_gnt, d_rvalid, d_rdata, d_misalign,
      output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata,
      output stall_if, stall_mem
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_func3, d_wdata,
      input  d_gnt, d_rvalid, d_rdata, d_misalign,
      input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata,
      input  stall_if, stall_mem
   );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 64-bit memory word: byte enables, shifted store
// data and misalignment detection from func3 and the low address bits.
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [2:0]  off,
   input  logic [63:0] wdata,
   output logic [7:0]  be,
   output logic [63:0] wdata_shifted,
   output logic        misalign
);

   logic unused_func3_msb;
   assign unused_func3_msb = func3[2];

   always_comb begin
      be       = 8'h00;
      misalign = 1'b0;
      case (size_of(func3[1:0]))
         SZ_B: be = 8'h01 << off;
         SZ_H: begin
            be       = 8'h03 << off;
            misalign = off[0];
         end
         SZ_W: begin
            be       = 8'h0F << off;
            misalign = |off[1:0];
         end
         SZ_D: begin
            be       = 8'hFF;
            misalign = |off;
         end
      endcase
   end

   assign wdata_shifted = wdata << {off, 3'b000};

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM stages onto one single-port 64-bit memory with a
// fixed read latency, one outstanding read, and a bounded data-grant streak.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 14,
   parameter int MEM_LAT    = 1,
   parameter int MAX_STREAK = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   localparam int                  STREAK_W   = $clog2(MAX_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(MAX_STREAK);
   localparam logic [2:0]          LAT_LOAD   = 3'(MEM_LAT - 1);

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   owner_t              owner_q, owner_d;
   logic                addr2_q, addr2_d;

   logic [7:0]          lane_be;
   logic [63:0]         lane_wdata;
   logic                lane_mis;

   logic                slot_free, pick_d, pick_if;
   logic                gnt_d, gnt_if, issue_d, rd_issue, en;
   logic                resp_if, resp_d;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr[63:ADDR_W+3], bus.if_addr[1:0],
                               bus.d_addr[63:ADDR_W+3]};

   mem_lane_align u_align (
      .func3         (bus.d_func3),
      .off           (bus.d_addr[2:0]),
      .wdata         (bus.d_wdata),
      .be            (lane_be),
      .wdata_shifted (lane_wdata),
      .misalign      (lane_mis)
   );

   // A misaligned data access still wins the slot so the MEM stage can move on,
   // but it never reaches the memory.
   always_comb begin
      slot_free = (state_q == IDLE) || (state_q == RESP);
      pick_d    = bus.d_req && (!bus.if_req || (streak_q < STREAK_CAP));
      pick_if   = !pick_d && bus.if_req;
      gnt_d     = slot_free && pick_d;
      gnt_if    = slot_free && pick_if;
      issue_d   = gnt_d && !lane_mis;
      en        = gnt_if || issue_d;
      rd_issue  = gnt_if || (issue_d && !bus.d_we);
      resp_if   = (state_q == RESP) && (owner_q == OWN_IF);
      resp_d    = (state_q == RESP) && (owner_q == OWN_D);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      streak_d = streak_q;
      owner_d  = owner_q;
      addr2_d  = addr2_q;

      case (state_q)
         IDLE, RESP: state_d = IDLE;
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rd_issue) begin
         owner_d = gnt_if ? OWN_IF : OWN_D;
         addr2_d = gnt_if ? bus.if_addr[2] : bus.d_addr[2];
         cnt_d   = LAT_LOAD;
         state_d = (MEM_LAT > 1) ? WAIT : RESP;
      end

      if (gnt_if) begin
         streak_d = '0;
      end else if (gnt_d) begin
         if (!bus.if_req) begin
            streak_d = '0;
         end else if (streak_q != STREAK_CAP) begin
            streak_d = streak_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         streak_q <= '0;
         owner_q  <= OWN_IF;
         addr2_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         streak_q <= streak_d;
         owner_q  <= owner_d;
         addr2_q  <= addr2_d;
      end
   end

   // Grants are combinational on the requests, so they are masked while reset
   // is held to keep the memory and pipeline quiet.
   assign bus.if_gnt     = reset && gnt_if;
   assign bus.d_gnt      = reset && gnt_d;
   assign bus.d_misalign = reset && gnt_d && lane_mis;
   assign bus.mem_en     = reset && en;
   assign bus.mem_we     = reset && issue_d && bus.d_we;
   assign bus.mem_addr   = !(reset && en) ? '0 :
                           gnt_if ? bus.if_addr[ADDR_W+2:3] : bus.d_addr[ADDR_W+2:3];
   assign bus.mem_be     = (reset && issue_d && bus.d_we) ? lane_be : 8'h00;
   assign bus.mem_wdata  = (reset && issue_d && bus.d_we) ? lane_wdata : 64'h0;

   assign bus.if_rvalid  = resp_if;
   assign bus.d_rvalid   = resp_d;
   assign bus.if_rdata   = !resp_if ? 32'h0 :
                           addr2_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
   assign bus.d_rdata    = resp_d ? bus.mem_rdata : 64'h0;

   assign bus.stall_if   = bus.if_req && !bus.if_rvalid;
   assign bus.stall_mem  = bus.d_req && !((bus.d_gnt && bus.d_we) || bus.d_rvalid ||
                                          bus.d_misalign);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected read responses
// into a queue that a separate rvalid monitor pops and compares.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int ADDR_W     = 14;
   localparam int MEM_LAT    = 2;
   localparam int MAX_STREAK = 4;

   typedef struct {
      logic        is_if;
      logic [63:0] data;
      int          due;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   logic [63:0] mem_model [64];
   logic [63:0] rd_pipe [MEM_LAT];
   logic        mem_init = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .MEM_LAT    (MEM_LAT),
      .MAX_STREAK (MAX_STREAK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Memory macro model: word i starts as {0x1000_0000+i, 0x2000_0000+i};
   // read data appears MEM_LAT cycles after mem_en, junk otherwise.
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) begin
            mem_model[i] <= {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
         end
         mem_init <= 1'b1;
      end else if (bus.mem_en && bus.mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (bus.mem_be[b]) begin
               mem_model[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
         end
      end
      rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem_model[bus.mem_addr[5:0]]
                                                : 64'hBAD0_BAD0_BAD0_BAD0;
      for (int i = 1; i < MEM_LAT; i++) begin
         rd_pipe[i] <= rd_pipe[i-1];
      end
   end
   assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   task automatic expectRead(input logic is_if, input logic [63:0] data);
      exp_q.push_back(exp_t'{is_if: is_if, data: data, due: cyc + MEM_LAT});
   endtask

   task automatic applyStimulus(input logic ir, input logic [63:0] ia,
                                input logic dr, input logic dw,
                                input logic [63:0] da, input logic [2:0] f3,
                                input logic [63:0] wd);
      @(posedge clk);
      #1;
      bus.if_req  = ir;
      bus.if_addr = ia;
      bus.d_req   = dr;
      bus.d_we    = dw;
      bus.d_addr  = da;
      bus.d_func3 = f3;
      bus.d_wdata = wd;
      @(negedge clk);
   endtask

   task automatic holdCycle();
      @(posedge clk);
      #1;
      @(negedge clk);
   endtask

   // Monitor: every rvalid must match the oldest outstanding expectation in
   // owner, cycle and data.
   always @(negedge clk) begin
      if (bus.if_rvalid || bus.d_rvalid) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_rvalid", {62'h0, bus.if_rvalid, bus.d_rvalid}, 64'h0);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("rvalid_owner", {62'h0, bus.if_rvalid, bus.d_rvalid},
                        mon_e.is_if ? 64'h2 : 64'h1);
            checkOutput("rvalid_cycle", 64'(cyc), 64'(mon_e.due));
            checkOutput("rdata", mon_e.is_if ? {32'h0, bus.if_rdata} : bus.d_rdata,
                        mon_e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic is_if;
      logic exp_stall;
      bus.if_req  = 1'b1;
      bus.if_addr = 64'h104;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 64'h8;
      bus.d_func3 = 3'b011;
      bus.d_wdata = 64'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_if_gnt", bus.if_gnt, 0);
      checkOutput("rst_d_gnt", bus.d_gnt, 0);
      checkOutput("rst_mem_en", bus.mem_en, 0);
      checkOutput("rst_mem_addr", 64'(bus.mem_addr), 0);
      checkOutput("rst_stall_if", bus.stall_if, 1);
      @(posedge clk);
      #1;
      reset       = 1'b1;
      bus.if_req  = 1'b0;
      bus.d_req   = 1'b0;

      $display("[TB] fetch only");
      applyStimulus(1, 64'h104, 0, 0, 0, 0, 0);
      checkOutput("f_if_gnt", bus.if_gnt, 1);
      checkOutput("f_d_gnt", bus.d_gnt, 0);
      checkOutput("f_mem_en", bus.mem_en, 1);
      checkOutput("f_mem_we", bus.mem_we, 0);
      checkOutput("f_mem_addr", 64'(bus.mem_addr), 64'h20);
      checkOutput("f_stall_t0", bus.stall_if, 1);
      expectRead(1, 64'h1000_0020);
      holdCycle();
      checkOutput("f_stall_t1", bus.stall_if, 1);
      checkOutput("f_wait_gnt", bus.if_gnt, 0);
      checkOutput("f_wait_en", bus.mem_en, 0);
      applyStimulus(1, 64'h108, 0, 0, 0, 0, 0);
      checkOutput("f_stall_t2", bus.stall_if, 0);
      checkOutput("f_b2b_gnt", bus.if_gnt, 1);
      checkOutput("f_b2b_addr", 64'(bus.mem_addr), 64'h21);
      expectRead(1, 64'h2000_0021);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      holdCycle();

      $display("[TB] fetch and load together");
      applyStimulus(1, 64'h1F0, 1, 0, 64'h18, 3'b011, 0);
      checkOutput("fl_d_gnt", bus.d_gnt, 1);
      checkOutput("fl_if_gnt", bus.if_gnt, 0);
      checkOutput("fl_mem_addr", 64'(bus.mem_addr), 64'h3);
      checkOutput("fl_stall_mem", bus.stall_mem, 1);
      expectRead(0, 64'h1000_0003_2000_0003);
      holdCycle();
      checkOutput("fl_wait_stall_mem", bus.stall_mem, 1);
      applyStimulus(1, 64'h1F0, 0, 0, 0, 0, 0);
      checkOutput("fl_resp_if_gnt", bus.if_gnt, 1);
      checkOutput("fl_resp_addr", 64'(bus.mem_addr), 64'h3E);
      expectRead(1, 64'h2000_003E);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      holdCycle();

      $display("[TB] streak limit");
      applyStimulus(1, 64'h0C, 1, 0, 64'h08, 3'b011, 0);
      for (int g = 0; g < 10; g++) begin
         if (g > 0) holdCycle();
         is_if     = ((g % 5) == 4);
         exp_stall = (g == 0) || (((g - 1) % 5) == 4);
         checkOutput($sformatf("streak_d_gnt_%0d", g), bus.d_gnt, !is_if);
         checkOutput($sformatf("streak_if_gnt_%0d", g), bus.if_gnt, is_if);
         checkOutput($sformatf("streak_stall_mem_%0d", g), bus.stall_mem, exp_stall);
         expectRead(is_if, is_if ? 64'h1000_0001 : 64'h1000_0001_2000_0001);
         holdCycle();
         checkOutput($sformatf("streak_wait_stall_%0d", g), bus.stall_mem, 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      holdCycle();

      $display("[TB] misalignment and byte store");
      applyStimulus(0, 0, 1, 1, 64'h13, 3'b001, 64'h1234);
      checkOutput("sh_mis", bus.d_misalign, 1);
      checkOutput("sh_mem_en", bus.mem_en, 0);
      checkOutput("sh_d_gnt", bus.d_gnt, 1);
      checkOutput("sh_stall_mem", bus.stall_mem, 0);
      applyStimulus(0, 0, 1, 0, 64'h06, 3'b010, 0);
      checkOutput("lw_mis", bus.d_misalign, 1);
      checkOutput("lw_mem_en", bus.mem_en, 0);
      applyStimulus(0, 0, 1, 1, 64'h15, 3'b000, 64'hAB);
      checkOutput("sb_mis", bus.d_misalign, 0);
      checkOutput("sb_mem_we", bus.mem_we, 1);
      checkOutput("sb_mem_be", 64'(bus.mem_be), 64'h20);
      checkOutput("sb_mem_wdata", bus.mem_wdata, 64'h0000_AB00_0000_0000);
      checkOutput("sb_mem_addr", 64'(bus.mem_addr), 64'h2);
      checkOutput("sb_stall_mem", bus.stall_mem, 0);
      applyStimulus(0, 0, 1, 0, 64'h10, 3'b011, 0);
      checkOutput("ld_after_sb_gnt", bus.d_gnt, 1);
      expectRead(0, 64'h1000_AB02_2000_0002);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      holdCycle();

      $display("[TB] double, word and half stores");
      applyStimulus(0, 0, 1, 1, 64'h40, 3'b011, 64'h1122_3344_5566_7788);
      checkOutput("sd_mem_be", 64'(bus.mem_be), 64'hFF);
      checkOutput("sd_mem_wdata", bus.mem_wdata, 64'h1122_3344_5566_7788);
      checkOutput("sd_mem_addr", 64'(bus.mem_addr), 64'h8);
      applyStimulus(0, 0, 1, 1, 64'h4C, 3'b010, 64'hDEAD_BEEF);
      checkOutput("sw_mem_be", 64'(bus.mem_be), 64'hF0);
      checkOutput("sw_mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF_0000_0000);
      applyStimulus(0, 0, 1, 1, 64'h0A, 3'b101, 64'h5A5A);
      checkOutput("sh_ok_mis", bus.d_misalign, 0);
      checkOutput("sh_ok_mem_be", 64'(bus.mem_be), 64'h0C);
      checkOutput("sh_ok_mem_wdata", bus.mem_wdata, 64'h5A5A_0000);
      applyStimulus(0, 0, 1, 0, 64'h40, 3'b011, 0);
      expectRead(0, 64'h1122_3344_5566_7788);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 64'h48, 3'b011, 0);
      expectRead(0, 64'hDEAD_BEEF_2000_0009);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      holdCycle();

      $display("[TB] reset during wait");
      applyStimulus(1, 64'h104, 0, 0, 0, 0, 0);
      checkOutput("rw_if_gnt", bus.if_gnt, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rw_gnt_in_rst", bus.if_gnt, 0);
      checkOutput("rw_en_in_rst", bus.mem_en, 0);
      checkOutput("rw_rvalid_in_rst", bus.if_rvalid, 0);
      checkOutput("rw_stall_if", bus.stall_if, 1);
      holdCycle();
      holdCycle();
      checkOutput("rw_no_rvalid", bus.if_rvalid, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rw_post_gnt", bus.if_gnt, 1);
      checkOutput("rw_post_addr", 64'(bus.mem_addr), 64'h20);
      expectRead(1, 64'h1000_0020);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      holdCycle();
      holdCycle();

      checkOutput("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, 64-bit-wide unified memory between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access with a fixed memory read latency and allows one outstanding transaction at a time.
- Generates stall_if and stall_mem for the hazard unit, which uses them to freeze the PC and the pipeline registers.
- Sits between the pipelined datapath and the memory macro; it replaces the separate imem/dmem ports.

Parameters:
- ADDR_W, 14: word-address width driven to the memory (64-bit words).
- MEM_LAT, 1: cycles from mem_en to valid mem_rdata. Legal range 1..7.
- MAX_STREAK, 4: maximum consecutive data grants while a fetch is pending, before the fetch is forced.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_rvalid.
- if_addr  in  64  byte address of the fetch (PC); bits [1:0] ignored.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  32  instruction word.
- d_req  in  1  data request; held high until completion.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  64  byte address of the data access.
- d_func3  in  3  access size: 000/100 = byte, 001/101 = half, 010/110 = word, 011 = double.
- d_wdata  in  64  store data, right-aligned.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid, one-cycle pulse.
- d_rdata  out  64  raw 64-bit memory word; the load unit does extension.
- d_misalign  out  1  one-cycle pulse: access rejected as misaligned.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address, taken from addr[ADDR_W+2:3].
- mem_be  out  8  byte-write enables.
- mem_wdata  out  64  store data shifted into byte lanes.
- mem_rdata  in  64  memory read data.
- stall_if  out  1  freeze PC and IF/ID.
- stall_mem  out  1  freeze MEM stage and all earlier stages.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; latency counter, streak counter and latched owner/addr[2] clear to 0.
  - All outputs except stall_if/stall_mem are 0.
  - Any in-flight read is dropped; no rvalid is issued after reset releases.
- FSM states are IDLE, WAIT and RESP.
- IDLE, grant choice:
  - If d_req is high and (if_req is low or streak < MAX_STREAK), grant data. Otherwise, if if_req is high, grant fetch.
  - In the grant cycle, pulse the gnt line; mem_en = 1 and mem_addr, mem_we, mem_be and mem_wdata are driven combinationally from the granted requester.
- Stores:
  - Complete in the grant cycle; there is no rvalid.
  - FSM stays in IDLE, so a new grant is possible on the next cycle.
- Reads:
  - Latch the owner and addr[2]. Load the counter with MEM_LAT-1.
  - Go to WAIT if MEM_LAT > 1, otherwise to RESP.
- WAIT: decrement the counter each cycle; when it reaches 0, go to RESP.
- RESP:
  - Pulse the owner's rvalid; the read completes exactly MEM_LAT cycles after its grant.
  - d_rdata = mem_rdata.
  - if_rdata = mem_rdata[63:32] if latched addr[2] = 1, else [31:0].
  - In the same cycle, apply the IDLE grant rules, so back-to-back reads have zero bubble.
- Streak counter:
  - Increments on each data grant while if_req is high, saturating at MAX_STREAK.
  - Clears on any fetch grant, or on a data grant while if_req is low.
- Byte lanes: with off = d_addr[2:0],
  - byte: be = 0x01<<off
  - half: be = 0x03<<off
  - word: be = 0x0F<<off
  - double: be = 0xFF
  - mem_wdata = d_wdata << (8*off).
- Misalignment:
  - Half with off[0] set, word with off[1:0] non-zero, or double with off non-zero.
  - Arbiter asserts d_misalign, never issues mem_en, and returns d_gnt only as if the access were complete, freeing stall_mem.
- Stalls (combinational):
  - stall_if = if_req & ~if_rvalid.
  - stall_mem = d_req & ~((d_gnt & d_we) | d_rvalid | d_misalign).
- If requests drop mid-transaction (which is illegal), the response is still pulsed.
- Fetch addresses are never checked for misalignment.

Decomposition:
- Shared package: FSM state encoding (IDLE/WAIT/RESP); func3 size constants (SZ_B, SZ_H, SZ_W, SZ_D); owner encoding (OWN_IF, OWN_D).
- One sub-module, mem_lane_align: combinational; derives be, shifted wdata and misalign from func3/addr. It is reusable by the load-extension unit.

Test Plan:
- Fetch only, MEM_LAT = 2, if_addr = 0x104 → if_gnt at T0; mem_addr = 0x20; if_rvalid at T2 with if_rdata = mem_rdata[63:32]; stall_if high for T0..T1.
- Fetch and load requested together, MEM_LAT = 1 → d_gnt first; d_rvalid at T1 with the fetch granted in the same cycle; if_rvalid at T2.
- Continuous d_req and if_req, MAX_STREAK = 4 → exactly 4 data grants, then 1 fetch grant, repeating.
- SH to 0x13 → d_misalign pulse, mem_en never asserted, stall_mem released. SB of 0xAB to 0x15 → mem_be = 0x20 and mem_wdata[47:40] = 0xAB.
- SD of 0x1122334455667788 to 0x40, then LD from 0x40 → mem_be = 0xFF; d_rdata = 0x1122334455667788.
- reset asserted low during WAIT → outputs zero immediately; no rvalid after release; first post-reset grant is correct.
